// File: rtl/muldiv_pkg.sv
// Shared types and constants for the radix-2 RV32M multiply/divide sequencer.
// The optional divide hardware is controlled by the MULDIV_DIV_EN macro.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MULDIV_ITER = 32;

    // Two's-complement magnitude of a 32-bit operand when its sign is to be honoured.
    function automatic logic [31:0] absVal(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// The divide path only exists when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]   i_acc,
    input  logic [DATA_W-1:0]   i_operand,
`ifdef MULDIV_DIV_EN
    input  logic                i_isDiv,
`endif
    output logic [2*DATA_W:0]   o_accNext
);

    logic [DATA_W:0]     w_mulSum;
    logic [DATA_W:0]     w_addend;
    logic [2*DATA_W:0]   w_mulNext;

    // Multiply: the upper half plus carry receives the multiplicand when the
    // current multiplier bit (acc[0]) is set, then the whole product shifts right.
    assign w_addend  = i_acc[0] ? {1'b0, i_operand} : '0;
    assign w_mulSum  = i_acc[2*DATA_W:DATA_W] + w_addend;
    assign w_mulNext = {1'b0, w_mulSum, i_acc[DATA_W-1:1]};

`ifdef MULDIV_DIV_EN
    logic [2*DATA_W:0]   w_shifted;
    logic [DATA_W:0]     w_trial;
    logic [2*DATA_W:0]   w_divNext;

    // Divide: remainder lives in the upper half, quotient bits enter at bit 0.
    assign w_shifted = {i_acc[2*DATA_W-1:0], 1'b0};
    assign w_trial   = w_shifted[2*DATA_W:DATA_W] - {1'b0, i_operand};
    assign w_divNext = w_trial[DATA_W] ? {1'b0, w_shifted[2*DATA_W-1:0]}
                                       : {1'b0, w_trial[DATA_W-1:0], w_shifted[DATA_W-1:1], 1'b1};

    assign o_accNext = i_isDiv ? w_divNext : w_mulNext;
`else
    assign o_accNext = w_mulNext;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer (IDLE/RUN/FIX/DONE) sharing one step datapath.
// Define MULDIV_DIV_EN to include DIV/DIVU/REM/REMU; otherwise those codes return 0.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                kill,
    input  logic [2:0]          Funct3,
    input  logic [DATA_W-1:0]   SrcA,
    input  logic [DATA_W-1:0]   SrcB,
    output logic                busy,
    output logic                stall,
    output logic                done,
    output logic [DATA_W-1:0]   Result
);

    muldiv_state_t       r_state;
    logic [2:0]          r_funct3;
    logic                r_signA;
    logic                r_signB;
    logic [DATA_W-1:0]   r_operand;
    logic [2*DATA_W:0]   r_acc;
    logic [4:0]          r_count;
    logic                r_special;
    logic [DATA_W-1:0]   r_specialVal;
    logic [DATA_W-1:0]   r_result;

    logic                w_accept;
    logic                w_aSigned;
    logic                w_bSigned;
    logic                w_signA;
    logic                w_signB;
    logic [DATA_W-1:0]   w_magA;
    logic [DATA_W-1:0]   w_magB;
    logic                w_special;
    logic [DATA_W-1:0]   w_specialVal;
    logic [2*DATA_W:0]   w_accNext;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_fixResult;

    assign w_accept = (r_state == IDLE) && start && !kill;

    // MULHSU treats only rs1 as signed; MULHU/DIVU/REMU and MUL's low word are unsigned.
    always_comb begin
        w_aSigned = 1'b0;
        w_bSigned = 1'b0;
        case (Funct3)
            F3_MULH:   begin w_aSigned = 1'b1; w_bSigned = 1'b1; end
            F3_MULHSU: begin w_aSigned = 1'b1; end
`ifdef MULDIV_DIV_EN
            F3_DIV,
            F3_REM:    begin w_aSigned = 1'b1; w_bSigned = 1'b1; end
`endif
            default:   ;
        endcase
    end

    assign w_signA = w_aSigned & SrcA[DATA_W-1];
    assign w_signB = w_bSigned & SrcB[DATA_W-1];
    assign w_magA  = absVal(SrcA, w_signA);
    assign w_magB  = absVal(SrcB, w_signB);

    // Cases resolved without iterating; the result is chosen now and applied in FIX.
    always_comb begin
        w_special    = 1'b0;
        w_specialVal = '0;
`ifdef MULDIV_DIV_EN
        if (Funct3[2] && (SrcB == '0)) begin
            w_special    = 1'b1;
            w_specialVal = Funct3[1] ? SrcA : '1;
        end else if (((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                     (SrcA == {1'b1, {(DATA_W-1){1'b0}}}) && (SrcB == '1)) begin
            w_special    = 1'b1;
            w_specialVal = Funct3[1] ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
        end
`else
        w_special = Funct3[2];
`endif
    end

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
`ifdef MULDIV_DIV_EN
        .i_isDiv   (r_funct3[2]),
`endif
        .o_accNext (w_accNext)
    );

    assign w_prod = (r_signA ^ r_signB) ? (~r_acc[2*DATA_W-1:0] + 1'b1) : r_acc[2*DATA_W-1:0];

`ifdef MULDIV_DIV_EN
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_rem;

    // Quotient follows the sign XOR, remainder follows the dividend.
    assign w_quot = absVal(r_acc[DATA_W-1:0], r_signA ^ r_signB);
    assign w_rem  = absVal(r_acc[2*DATA_W-1:DATA_W], r_signA);
`endif

    always_comb begin
        w_fixResult = '0;
        if (r_special) begin
            w_fixResult = r_specialVal;
        end else begin
            case (r_funct3)
                F3_MUL:    w_fixResult = w_prod[DATA_W-1:0];
                F3_MULH,
                F3_MULHSU,
                F3_MULHU:  w_fixResult = w_prod[2*DATA_W-1:DATA_W];
`ifdef MULDIV_DIV_EN
                F3_DIV,
                F3_DIVU:   w_fixResult = w_quot;
                F3_REM,
                F3_REMU:   w_fixResult = w_rem;
`endif
                default:   w_fixResult = '0;
            endcase
        end
    end

    // Reset beats kill, kill beats everything else; Result is only written in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_funct3     <= '0;
            r_signA      <= 1'b0;
            r_signB      <= 1'b0;
            r_operand    <= '0;
            r_acc        <= '0;
            r_count      <= '0;
            r_special    <= 1'b0;
            r_specialVal <= '0;
            r_result     <= '0;
        end else if (kill) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3     <= Funct3;
                        r_signA      <= w_signA;
                        r_signB      <= w_signB;
                        r_operand    <= Funct3[2] ? w_magB : w_magA;
                        r_acc        <= {{(DATA_W+1){1'b0}}, (Funct3[2] ? w_magA : w_magB)};
                        r_count      <= '0;
                        r_special    <= w_special;
                        r_specialVal <= w_specialVal;
                        r_state      <= w_special ? FIX : RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_accNext;
                    if (r_count == 5'(MULDIV_ITER - 1)) begin
                        r_state <= FIX;
                    end else begin
                        r_count <= r_count + 5'd1;
                    end
                end
                FIX: begin
                    r_result <= w_fixResult;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == RUN) || (r_state == FIX);
    assign done   = (r_state == DONE);
    assign stall  = w_accept || (r_state == RUN) || (r_state == FIX);
    assign Result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; divide vectors run only with MULDIV_DIV_EN.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] Result;

    int errCount;
    int checkCount;
    logic [31:0] lastRes;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request and follows it to done; latency counts edges after the start edge.
    task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input int expLat, input logic [31:0] expRes);
        int lat;
        int stallCnt;
        @(negedge clk);
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        #1;
        checkOutput({tag, " stall@start"}, {31'd0, stall}, 32'd1);
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        stallCnt = 0;
        while (!done && lat < 200) begin
            if (stall) stallCnt++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) lat = -1;
        checkOutput({tag, " latency"}, lat, expLat);
        checkOutput({tag, " result"}, Result, expRes);
        checkOutput({tag, " stallcycles"}, stallCnt, expLat);
        checkOutput({tag, " stall@done"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        checkOutput({tag, " donepulse"}, {31'd0, done}, 32'd0);
        lastRes = expRes;
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        lastRes    = 32'd0;
        reset  = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        Funct3 = 3'd0;
        SrcA   = 32'd0;
        SrcB   = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", Result, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle stall", {31'd0, stall}, 32'd0);

        applyStimulus("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB);
        applyStimulus("MULHU -1*-1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
        applyStimulus("MULH -1*-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000);
        applyStimulus("MULHSU -1*2",   3'b010, 32'hFFFFFFFF, 32'd2,        33, 32'hFFFFFFFF);
        applyStimulus("MUL 12345*678", 3'b000, 32'd12345,    32'd678,      33, 32'd8369910);

`ifdef MULDIV_DIV_EN
        applyStimulus("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD);
        applyStimulus("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF);
        applyStimulus("DIVU 100/7",    3'b101, 32'd100,      32'd7,        33, 32'd14);
        applyStimulus("REMU 100/7",    3'b111, 32'd100,      32'd7,        33, 32'd2);
        applyStimulus("DIVU 5/0",      3'b101, 32'd5,        32'd0,        1,  32'hFFFFFFFF);
        applyStimulus("REM 5/0",       3'b110, 32'd5,        32'd0,        1,  32'd5);
        applyStimulus("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000);
        applyStimulus("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 1,  32'd0);
`else
        applyStimulus("DIV 10/2 off",  3'b100, 32'd10,       32'd2,        1,  32'd0);
        applyStimulus("MUL 3*5",       3'b000, 32'd3,        32'd5,        33, 32'd15);
`endif

        // Flush partway through a multiply: no done, back to idle, Result untouched.
        @(negedge clk);
        Funct3 = 3'b000;
        SrcA   = 32'd9;
        SrcB   = 32'd9;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill busy", {31'd0, busy}, 32'd0);
        checkOutput("kill done", {31'd0, done}, 32'd0);
        checkOutput("kill result", Result, lastRes);
        applyStimulus("MUL after kill", 3'b000, 32'd6, 32'd7, 33, 32'd42);

        // Kill and start together in IDLE: request refused.
        @(negedge clk);
        start = 1'b1;
        kill  = 1'b1;
        #1;
        checkOutput("kill+start stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        checkOutput("kill+start busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of RUN clears all outputs on the next edge.
        @(negedge clk);
        Funct3 = 3'b011;
        SrcA   = 32'd1000;
        SrcB   = 32'd1000;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("prereset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrun reset busy", {31'd0, busy}, 32'd0);
        checkOutput("midrun reset done", {31'd0, done}, 32'd0);
        checkOutput("midrun reset stall", {31'd0, stall}, 32'd0);
        checkOutput("midrun reset result", Result, 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
